// File: rtl/io_bus_arbiter_pkg.sv
// Shared types and constants for the IO bus arbiter.
// The IO window is the 8 ports at addresses 0..7.
package io_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    DONE
  } state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  localparam logic [7:0] IO_WIN_MASK = 8'hF8;

  function automatic logic in_window(
    input logic [7:0] addr
  );
    return (addr & IO_WIN_MASK) == 8'h00;
  endfunction

endpackage

// File: rtl/io_bus_arbiter_if.sv
// Requester and IO-side bus bundle for the arbiter.
// slave = arbiter view, master = requesters plus IO block.
interface io_bus_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              cpu_err;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_ack;
  logic              dma_err;

  logic [ADDR_W-1:0] io_addr;
  logic [DATA_W-1:0] io_din;
  logic              io_re;
  logic              io_we;
  logic [DATA_W-1:0] io_dout;
  logic              busy;

  modport slave (
    input  cpu_req, cpu_we,
    input  cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_err,
    input  dma_req, dma_we,
    input  dma_addr, dma_wdata,
    output dma_rdata, dma_ack, dma_err,
    output io_addr, io_din,
    output io_re, io_we,
    input  io_dout,
    output busy
  );

  modport master (
    output cpu_req, cpu_we,
    output cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_err,
    output dma_req, dma_we,
    output dma_addr, dma_wdata,
    input  dma_rdata, dma_ack, dma_err,
    input  io_addr, io_din,
    input  io_re, io_we,
    output io_dout,
    input  busy
  );

endinterface

// File: rtl/io_bus_arbiter_rr.sv
// Two-way round-robin pick; last_grant is
// held by the parent so this stays combinational.
module io_rr_arbiter
  import io_bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant
);

  always_comb begin
    grant = REQ_CPU;
    unique case (1'b1)
      (req == 2'b11): grant = ~last_grant;
      (req == 2'b10): grant = REQ_DMA;
      default:        grant = REQ_CPU;
    endcase
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Shares the IO port block between CPU and DMA;
// each access runs setup, strobe, done.
module io_bus_arbiter
  import io_bus_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int ADDR_W        = 8,
  parameter int STROBE_CYCLES = 2
) (
  input logic             clk,
  input logic             rst_n,
  io_bus_arbiter_if.slave bus
);

  localparam logic [3:0] STB_LAST =
    4'(STROBE_CYCLES - 1);

  state_t            state;
  logic              last_grant;
  logic              win_l;
  logic              we_l;
  logic              err_flag;
  logic [ADDR_W-1:0] addr_l;
  logic [DATA_W-1:0] wdata_l;
  logic [3:0]        cnt;

  logic [ADDR_W-1:0] io_addr_q;
  logic [DATA_W-1:0] io_din_q;
  logic              io_re_q;
  logic              io_we_q;
  logic [1:0]        ack_q;
  logic [1:0]        err_q;
  logic [DATA_W-1:0] rdata_q [2];

  logic [1:0]        req;
  logic              grant;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_win;

  assign req = {bus.dma_req, bus.cpu_req};

  io_rr_arbiter u_rr (
    .req        (req),
    .last_grant (last_grant),
    .grant      (grant)
  );

  always_comb begin
    sel_we    = bus.cpu_we;
    sel_addr  = bus.cpu_addr;
    sel_wdata = bus.cpu_wdata;
    if (grant == REQ_DMA) begin
      sel_we    = bus.dma_we;
      sel_addr  = bus.dma_addr;
      sel_wdata = bus.dma_wdata;
    end
    sel_win = in_window(sel_addr[7:0]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= REQ_DMA;
      win_l      <= REQ_CPU;
      we_l       <= 1'b0;
      err_flag   <= 1'b0;
      addr_l     <= '0;
      wdata_l    <= '0;
      cnt        <= '0;
      io_addr_q  <= '0;
      io_din_q   <= '0;
      io_re_q    <= 1'b0;
      io_we_q    <= 1'b0;
      ack_q      <= '0;
      err_q      <= '0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      ack_q <= '0;
      err_q <= '0;
      unique case (state)
        IDLE: begin
          if (|req) begin
            win_l   <= grant;
            we_l    <= sel_we;
            addr_l  <= sel_addr;
            wdata_l <= sel_wdata;
            if (sel_win) begin
              state     <= SETUP;
              io_addr_q <= sel_addr;
              io_din_q  <= sel_wdata;
            end else begin
              // rejected locally, IO block never sees it
              state        <= DONE;
              err_flag     <= 1'b1;
              ack_q[grant] <= 1'b1;
              err_q[grant] <= 1'b1;
              if (!sel_we)
                rdata_q[grant] <= '0;
            end
          end
        end
        SETUP: begin
          state   <= STROBE;
          cnt     <= STB_LAST;
          io_re_q <= ~we_l;
          io_we_q <= we_l;
        end
        STROBE: begin
          if (cnt == 4'd0) begin
            state        <= DONE;
            io_re_q      <= 1'b0;
            io_we_q      <= 1'b0;
            ack_q[win_l] <= 1'b1;
            err_q[win_l] <= err_flag;
            if (!we_l)
              rdata_q[win_l] <= bus.io_dout;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state      <= IDLE;
          last_grant <= win_l;
          err_flag   <= 1'b0;
          io_addr_q  <= '0;
          io_din_q   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.io_addr   = io_addr_q;
  assign bus.io_din    = io_din_q;
  assign bus.io_re     = io_re_q;
  assign bus.io_we     = io_we_q;
  assign bus.cpu_ack   = ack_q[REQ_CPU];
  assign bus.cpu_err   = err_q[REQ_CPU];
  assign bus.cpu_rdata = rdata_q[REQ_CPU];
  assign bus.dma_ack   = ack_q[REQ_DMA];
  assign bus.dma_err   = err_q[REQ_DMA];
  assign bus.dma_rdata = rdata_q[REQ_DMA];
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Scoreboard bench for io_bus_arbiter, with a
// STROBE_CYCLES=2 instance and a STROBE_CYCLES=1 instance.
module tb_io_bus_arbiter;

  typedef struct {
    int         cyc;
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;
  bit mon_on = 1'b0;

  logic       req_d   [2][2];
  logic       we_d    [2][2];
  logic [7:0] addr_d  [2][2];
  logic [7:0] wdata_d [2][2];

  logic       ack_o   [2][2];
  logic       err_o   [2][2];
  logic [7:0] rdata_o [2][2];
  logic       re_o    [2];
  logic       we_o    [2];
  logic       busy_o  [2];
  logic [7:0] ioa_o   [2];
  logic [7:0] iod_o   [2];

  logic [7:0] ref_mem [2][8];
  logic [7:0] last_rd [2][2];
  exp_t       sb [4][$];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [7:0] mem [8] = '{8'h00, 8'h11, 8'h22,
      8'h33, 8'h44, 8'h3C, 8'h66, 8'h77};

    io_bus_arbiter_if #(.DATA_W(8), .ADDR_W(8)) bus ();

    io_bus_arbiter #(
      .DATA_W        (8),
      .ADDR_W        (8),
      .STROBE_CYCLES ((g == 0) ? 2 : 1)
    ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );

    assign bus.cpu_req   = req_d[g][0];
    assign bus.cpu_we    = we_d[g][0];
    assign bus.cpu_addr  = addr_d[g][0];
    assign bus.cpu_wdata = wdata_d[g][0];
    assign bus.dma_req   = req_d[g][1];
    assign bus.dma_we    = we_d[g][1];
    assign bus.dma_addr  = addr_d[g][1];
    assign bus.dma_wdata = wdata_d[g][1];
    assign bus.io_dout   = mem[bus.io_addr[2:0]];

    assign ack_o[g][0]   = bus.cpu_ack;
    assign err_o[g][0]   = bus.cpu_err;
    assign rdata_o[g][0] = bus.cpu_rdata;
    assign ack_o[g][1]   = bus.dma_ack;
    assign err_o[g][1]   = bus.dma_err;
    assign rdata_o[g][1] = bus.dma_rdata;
    assign re_o[g]       = bus.io_re;
    assign we_o[g]       = bus.io_we;
    assign busy_o[g]     = bus.busy;
    assign ioa_o[g]      = bus.io_addr;
    assign iod_o[g]      = bus.io_din;

    always @(posedge clk)
      if (bus.io_we) mem[bus.io_addr[2:0]] <= bus.io_din;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h",
                  tag, got, exp);
  endtask

  function automatic int stb(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic void expect_acc(
    input int d, input int p, input logic w,
    input logic [7:0] a, input logic [7:0] wd,
    input int ack_cyc);
    exp_t e;
    logic inw;
    inw = (a[7:3] == 5'd0);
    if (!w) last_rd[d][p] = inw ? ref_mem[d][a[2:0]] : 8'h00;
    else if (inw) ref_mem[d][a[2:0]] = wd;
    e.cyc   = ack_cyc;
    e.rdata = last_rd[d][p];
    e.err   = !inw;
    sb[d*2+p].push_back(e);
  endfunction

  task automatic go(input int d, input int p, input logic w,
                    input logic [7:0] a, input logic [7:0] wd);
    req_d[d][p]   = 1'b1;
    we_d[d][p]    = w;
    addr_d[d][p]  = a;
    wdata_d[d][p] = wd;
  endtask

  task automatic to_cycle(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ack(input int d, input int p, input bit chk,
                          input logic w, input logic inw);
    int nre;
    int nwe;
    bit got;
    nre = 0;
    nwe = 0;
    got = 1'b0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      if (chk) begin
        nre += int'(re_o[d]);
        nwe += int'(we_o[d]);
      end
      if (ack_o[d][p]) got = 1'b1;
    end
    check($sformatf("ack_seen d%0d p%0d", d, p), 32'(got), 1);
    if (chk) begin
      check($sformatf("re_cycles d%0d", d), nre,
            (inw && !w) ? stb(d) : 0);
      check($sformatf("we_cycles d%0d", d), nwe,
            (inw && w) ? stb(d) : 0);
    end
    @(posedge clk);
    #1;
    req_d[d][p] = 1'b0;
  endtask

  task automatic access(input int d, input int p, input logic w,
                        input logic [7:0] a, input logic [7:0] wd);
    int t0;
    logic inw;
    inw = (a[7:3] == 5'd0);
    @(posedge clk);
    #1;
    t0 = cyc;
    expect_acc(d, p, w, a, wd, inw ? t0 + 2 + stb(d) : t0 + 1);
    go(d, p, w, a, wd);
    wait_ack(d, p, 1'b1, w, inw);
  endtask

  task automatic rnd(input int d, input int p, input int n);
    for (int i = 0; i < n; i++) begin
      logic       w;
      logic [7:0] a;
      logic [7:0] wd;
      logic [4:0] hi;
      logic [1:0] lo;
      logic       pb;
      w  = 1'($urandom_range(0, 1));
      wd = 8'($urandom);
      hi = 5'($urandom_range(1, 31));
      lo = 2'($urandom_range(0, 3));
      pb = (p == 1);
      if ($urandom_range(0, 7) == 0) a = {hi, 3'b000};
      else a = {5'b00000, pb, lo};
      @(posedge clk);
      #1;
      expect_acc(d, p, w, a, wd, -1);
      go(d, p, w, a, wd);
      wait_ack(d, p, 1'b0, w, 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   k;
    if (mon_on) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("overlap d%0d", d),
              32'(re_o[d] & we_o[d]), 0);
        check($sformatf("strobe_idle d%0d", d),
              32'((re_o[d] | we_o[d]) & ~busy_o[d]), 0);
        for (int p = 0; p < 2; p++) begin
          k = d * 2 + p;
          check($sformatf("err_wo_ack d%0d p%0d", d, p),
                32'(err_o[d][p] & ~ack_o[d][p]), 0);
          if (ack_o[d][p]) begin
            check($sformatf("ack_expected d%0d p%0d", d, p),
                  32'(sb[k].size() != 0), 1);
            if (sb[k].size() != 0) begin
              e = sb[k].pop_front();
              if (e.cyc >= 0)
                check($sformatf("ack_cyc d%0d p%0d", d, p),
                      cyc, e.cyc);
              check($sformatf("rdata d%0d p%0d", d, p),
                    32'(rdata_o[d][p]), 32'(e.rdata));
              check($sformatf("err d%0d p%0d", d, p),
                    32'(err_o[d][p]), 32'(e.err));
            end
          end
        end
      end
    end
  end

  initial begin
    int t0;
    for (int d = 0; d < 2; d++) begin
      ref_mem[d] = '{8'h00, 8'h11, 8'h22, 8'h33,
                     8'h44, 8'h3C, 8'h66, 8'h77};
      for (int p = 0; p < 2; p++) begin
        req_d[d][p]   = 1'b0;
        we_d[d][p]    = 1'b0;
        addr_d[d][p]  = 8'h00;
        wdata_d[d][p] = 8'h00;
        last_rd[d][p] = 8'h00;
      end
    end

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_on = 1'b1;
    @(negedge clk);
    check("rst busy", 32'(busy_o[0]), 0);
    check("rst io_re", 32'(re_o[0]), 0);
    check("rst io_we", 32'(we_o[0]), 0);
    check("rst io_addr", 32'(ioa_o[0]), 0);
    check("rst cpu_rdata", 32'(rdata_o[0][0]), 0);
    check("rst dma_rdata", 32'(rdata_o[0][1]), 0);
    check("rst busy d1", 32'(busy_o[1]), 0);

    // CPU write 3 <= A5 with per-cycle bus checks
    @(posedge clk);
    #1;
    t0 = cyc;
    expect_acc(0, 0, 1'b1, 8'h03, 8'hA5, t0 + 4);
    go(0, 0, 1'b1, 8'h03, 8'hA5);
    @(negedge clk);
    @(negedge clk);
    check("setup busy", 32'(busy_o[0]), 1);
    check("setup io_we", 32'(we_o[0]), 0);
    check("setup io_addr", 32'(ioa_o[0]), 3);
    @(negedge clk);
    check("stb1 io_we", 32'(we_o[0]), 1);
    check("stb1 io_re", 32'(re_o[0]), 0);
    check("stb1 io_addr", 32'(ioa_o[0]), 3);
    check("stb1 io_din", 32'(iod_o[0]), 32'hA5);
    @(negedge clk);
    check("stb2 io_we", 32'(we_o[0]), 1);
    check("stb2 io_din", 32'(iod_o[0]), 32'hA5);
    wait_ack(0, 0, 1'b0, 1'b1, 1'b1);

    access(0, 0, 1'b0, 8'h05, 8'h00);
    check("dma_rdata hold", 32'(rdata_o[0][1]), 0);

    // contention from reset: CPU, DMA, CPU again
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    last_rd[0] = '{8'h00, 8'h00};
    last_rd[1] = '{8'h00, 8'h00};
    t0 = cyc;
    expect_acc(0, 0, 1'b1, 8'h01, 8'h5A, t0 + 4);
    expect_acc(0, 1, 1'b0, 8'h06, 8'h00, t0 + 9);
    expect_acc(0, 0, 1'b0, 8'h01, 8'h00, t0 + 14);
    go(0, 0, 1'b1, 8'h01, 8'h5A);
    go(0, 1, 1'b0, 8'h06, 8'h00);
    to_cycle(t0 + 5);
    go(0, 0, 1'b0, 8'h01, 8'h00);
    to_cycle(t0 + 10);
    req_d[0][1] = 1'b0;
    to_cycle(t0 + 15);
    req_d[0][0] = 1'b0;
    check("rr cpu drained", sb[0].size(), 0);
    check("rr dma drained", sb[1].size(), 0);

    access(0, 1, 1'b0, 8'h10, 8'h00);
    access(0, 0, 1'b0, 8'h03, 8'h00);

    // reset lands in the middle of a write strobe
    @(posedge clk);
    #1;
    t0 = cyc;
    go(0, 0, 1'b1, 8'h02, 8'h77);
    to_cycle(t0 + 2);
    rst_n = 1'b0;
    req_d[0][0] = 1'b0;
    @(negedge clk);
    check("pre-abort io_we", 32'(we_o[0]), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ref_mem[0][2] = 8'h77;
    last_rd[0] = '{8'h00, 8'h00};
    last_rd[1] = '{8'h00, 8'h00};
    @(negedge clk);
    check("abort io_we", 32'(we_o[0]), 0);
    check("abort busy", 32'(busy_o[0]), 0);
    to_cycle(t0 + 4);
    @(negedge clk);
    check("abort no ack", 32'(ack_o[0][0]), 0);
    access(0, 0, 1'b0, 8'h02, 8'h00);

    access(1, 0, 1'b0, 8'h05, 8'h00);
    access(1, 1, 1'b1, 8'h04, 8'hC3);
    access(1, 1, 1'b0, 8'h04, 8'h00);

    fork
      rnd(0, 0, 50);
      rnd(0, 1, 50);
      rnd(1, 0, 50);
      rnd(1, 1, 50);
    join

    repeat (5) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++)
      check($sformatf("sb_empty %0d", k), sb[k].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
Shares the 8-port memory-mapped IO block between two requesters, the CPU (index 0) and the DMA engine (index 1). It sequences every access as setup, then strobe, then ack, so the IO block sees clean, single-owner RE/WE pulses. Addresses outside the IO window (addr[7:3] != 0) are rejected locally with an error response and never reach the IO block. Sits between the CPU/DMA bus masters and the IO port block.

Parameters:
DATA_W, 8, data width of requester and IO buses
ADDR_W, 8, address width
STROBE_CYCLES, 2, cycles io_re/io_we held high per access (legal range 1..15)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
cpu_req  in  1  CPU access request, level
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU target address
cpu_wdata  in  DATA_W  CPU write data
cpu_rdata  out  DATA_W  CPU read data, valid with cpu_ack
cpu_ack  out  1  one-cycle completion pulse
cpu_err  out  1  one-cycle pulse with cpu_ack when the address was out of window
dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ack, dma_err  same as the cpu_* ports, for the DMA
io_addr  out  ADDR_W  to IO block addr
io_din  out  DATA_W  to IO block Din
io_re  out  1  to IO block RE
io_we  out  1  to IO block WE
io_dout  in  DATA_W  from IO block Dout
busy  out  1  high in any state other than IDLE

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset values:
  - state = IDLE; all outputs 0.
  - last_grant = 1, so the CPU wins the first contention.
- FSM states: IDLE, SETUP, STROBE, DONE.
- IDLE:
  - If any req is high, pick the winner and latch its we/addr/wdata into internal registers. Requester inputs are ignored after latching.
  - In-window address: go to SETUP.
  - Out-of-window address: go to DONE with err_flag = 1.
- SETUP (1 cycle):
  - io_addr/io_din driven from the latched registers; io_re = io_we = 0.
  - Go to STROBE; load strobe counter with STROBE_CYCLES-1.
- STROBE:
  - io_re = ~we_l, io_we = we_l. io_addr/io_din stay stable for the whole state.
  - Counter decrements each cycle. On the counter==0 cycle, a read samples io_dout into the winner's rdata register; then go to DONE.
- DONE (1 cycle):
  - Strobes low; winner's ack = 1; err = err_flag.
  - last_grant <= winner; clear err_flag; go to IDLE.
- io_addr/io_din return to 0 in IDLE.
- Latency, counting the cycle req is sampled in IDLE as cycle 0:
  - Ack at cycle 2+STROBE_CYCLES (cycle 4 with the default).
  - Out-of-window ack at cycle 1, with no strobe ever raised.
- Arbitration (round-robin):
  - Both req high in IDLE: grant the requester that is not last_grant.
  - Single req: grant it regardless of last_grant.
  - A requester re-asserting in the cycle after its ack, while the other is waiting, loses.
- Requester rules:
  - Hold req until ack. Deassert or re-request the cycle after ack.
  - A req dropped mid-access does not abort; the access completes and ack still pulses.
- rdata:
  - Each requester's rdata holds its last read value until that requester's next read completes.
  - Writes and errors leave rdata unchanged, except an out-of-window read, which sets rdata to 0.
- io_re and io_we are never high together, and never high outside STROBE.
- Reset asserted mid-access: the next cycle is IDLE with all strobes and acks 0. No ack is issued for the aborted access.

Decomposition:
- Shared package io_bus_pkg holds:
  - state enum {IDLE, SETUP, STROBE, DONE}
  - REQ_CPU = 0, REQ_DMA = 1
  - IO_WIN_MASK = 8'hF8 (in window when (addr & mask) == 0)
- Sub-module io_rr_arbiter: 2-way round-robin with inputs req[1:0], last_grant, and output grant index. Purely combinational; last_grant is owned by the parent.

Test Plan:
- Reset, then CPU write addr 3 data 8'hA5: SETUP at cycle 1; io_we high cycles 2-3 with io_addr = 3, io_din = A5; cpu_ack at cycle 4; io_re never high.
- CPU read addr 5 with io_dout = 8'h3C: io_re high cycles 2-3; cpu_rdata = 3C with cpu_ack at cycle 4; dma_rdata unchanged.
- CPU and DMA request simultaneously from reset: CPU served first (ack cycle 4), DMA next (ack cycle 9). Hold both high: grants alternate CPU, DMA, CPU.
- DMA read addr 8'h10: dma_ack and dma_err at cycle 1, dma_rdata = 0, io_re/io_we stay 0; follow-up CPU access unaffected.
- rst_n low during STROBE of a CPU write: next cycle io_we = 0, state IDLE, no cpu_ack; a new request after reset completes normally.
- STROBE_CYCLES = 1 build: read ack at cycle 3. Check io_re/io_we never overlap across 100 random CPU/DMA accesses.
